// File: rtl/data_sync_tx_arbiter_if.sv
// Bundle of the requester and synchronizer-side signals of data_sync_tx_arbiter.
// The slave modport is the arbiter view; the master modport is the requester/bench view.
interface data_sync_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int BUS_WIDTH = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*BUS_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]           gnt;
  logic [ID_W-1:0]              gnt_id;
  logic                         busy;
  logic [BUS_WIDTH-1:0]         unsync_bus;
  logic                         bus_enable;

  modport master (
    output req, req_data,
    input  gnt, gnt_id, busy, unsync_bus, bus_enable
  );

  modport slave (
    input  req, req_data,
    output gnt, gnt_id, busy, unsync_bus, bus_enable
  );
endinterface

// File: rtl/data_sync_tx_arbiter.sv
// Source-side scheduler that shares one bus-synchronizer crossing between several
// requesters: round-robin pick, registered data, then a fixed high/low enable window
// so the destination synchronizer sees one clean, separated enable per transfer.
module data_sync_tx_arbiter #(
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input logic CLK,
  input logic RST,
  data_sync_tx_arbiter_if.slave bus
);

  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
  logic                 busy_q, busy_d;
  logic [BUS_WIDTH-1:0] unsync_bus_q, unsync_bus_d;
  logic                 bus_enable_q, bus_enable_d;

  logic                 found;
  logic [ID_W-1:0]      win;
  logic [ID_W:0]        cand;

  // Rotating search from the last winner, then next-state/output computation of the FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    gnt_d        = '0;
    gnt_id_d     = gnt_id_q;
    unsync_bus_d = unsync_bus_q;
    bus_enable_d = bus_enable_q;
    found        = 1'b0;
    win          = '0;
    cand         = '0;

    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!found && bus.req[cand[ID_W-1:0]]) begin
        found = 1'b1;
        win   = cand[ID_W-1:0];
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d[win]   = 1'b1;
          gnt_id_d     = win;
          ptr_d        = win;
          unsync_bus_d = bus.req_data[int'(win)*BUS_WIDTH +: BUS_WIDTH];
          bus_enable_d = 1'b1;
          state_d      = HOLD;
          cnt_d        = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          bus_enable_d = 1'b0;
          state_d      = GAP;
          cnt_d        = CNT_W'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        bus_enable_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // All state and outputs registered; reset abandons any transfer in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ptr_q        <= ID_W'(NUM_REQ - 1);
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      busy_q       <= 1'b0;
      unsync_bus_q <= '0;
      bus_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      busy_q       <= busy_d;
      unsync_bus_q <= unsync_bus_d;
      bus_enable_q <= bus_enable_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.gnt_id     = gnt_id_q;
  assign bus.busy       = busy_q;
  assign bus.unsync_bus = unsync_bus_q;
  assign bus.bus_enable = bus_enable_q;

endmodule

// File: tb/tb_data_sync_tx_arbiter.sv
// Self-checking bench for data_sync_tx_arbiter: directed scenarios followed by random
// requests, scored against a timeline model of grants and enable windows.
module tb_data_sync_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 4;
  localparam int G = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  int checks = 0;
  int fails  = 0;

  data_sync_tx_arbiter_if #(.NUM_REQ(N), .BUS_WIDTH(W)) bus ();

  data_sync_tx_arbiter #(
    .BUS_WIDTH(W),
    .NUM_REQ(N),
    .HOLD_CYCLES(H),
    .GAP_CYCLES(G)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         w;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];

  // Reference model state: edge counter, earliest edge a new grant may occur, last grant.
  int           edge_n  = 0;
  int           next_ok = 0;
  int           last_g  = -1000;
  int           m_ptr   = N - 1;
  logic         exp_en   = 1'b0;
  logic         exp_busy = 1'b0;
  logic [W-1:0] exp_bus  = '0;
  int           exp_id   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a grant is possible once H+G+1 edges have passed since the last one.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_n   = 0;
      next_ok  = 0;
      last_g   = -1000;
      m_ptr    = N - 1;
      exp_en   = 1'b0;
      exp_busy = 1'b0;
      exp_bus  = '0;
      exp_id   = 0;
      sb.delete();
    end else begin
      edge_n++;
      if (edge_n >= next_ok && bus.req != '0) begin
        int w;
        bit hit;
        w   = 0;
        hit = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!hit && bus.req[(m_ptr + k) % N]) begin
            hit = 1'b1;
            w   = (m_ptr + k) % N;
          end
        end
        m_ptr   = w;
        last_g  = edge_n;
        next_ok = edge_n + H + G + 1;
        exp_id  = w;
        exp_bus = bus.req_data[w*W +: W];
        sb.push_back('{w, bus.req_data[w*W +: W]});
      end
      exp_en   = ((edge_n - last_g) < H);
      exp_busy = ((edge_n - last_g) < (H + G));
    end
  end

  // Monitor: pops the scoreboard on every presented cycle and checks the held outputs.
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t t;
      t = sb.pop_front();
      checkOutput("gnt", 32'(bus.gnt), 32'(1) << t.w);
      checkOutput("grant_id", 32'(bus.gnt_id), 32'(t.w));
      checkOutput("grant_data", 32'(bus.unsync_bus), 32'(t.data));
      checkOutput("grant_enable", 32'(bus.bus_enable), 32'd1);
    end else begin
      checkOutput("gnt_quiet", 32'(bus.gnt), 32'd0);
    end
    checkOutput("bus_enable", 32'(bus.bus_enable), 32'(exp_en));
    checkOutput("busy", 32'(bus.busy), 32'(exp_busy));
    checkOutput("unsync_bus", 32'(bus.unsync_bus), 32'(exp_bus));
    checkOutput("gnt_id", 32'(bus.gnt_id), 32'(exp_id));
  end

  // Drive one request pattern for a number of sampled edges; leaves time at posedge+2.
  task automatic applyStimulus(input logic [N-1:0] r, input int cycles);
    repeat (cycles) begin
      bus.req = r;
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic setData(input int i, input logic [W-1:0] v);
    bus.req_data[i*W +: W] = v;
  endtask

  // Asynchronous reset pulse with an immediate check that every output cleared.
  task automatic applyReset();
    @(negedge CLK);
    #1;
    RST = 1'b0;
    #1;
    checkOutput("rst_gnt", 32'(bus.gnt), 32'd0);
    checkOutput("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_unsync_bus", 32'(bus.unsync_bus), 32'd0);
    checkOutput("rst_bus_enable", 32'(bus.bus_enable), 32'd0);
    repeat (2) @(negedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #2;
  endtask

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    applyReset();

    // Single requester 2 with A5.
    setData(2, 8'hA5);
    applyStimulus(4'b0100, 1);
    applyStimulus(4'b0000, 12);

    // All requesting: rotation from the last winner.
    for (int i = 0; i < N; i++) setData(i, 8'h10 + 8'(i));
    applyStimulus(4'b1111, 45);
    applyStimulus(4'b0000, 10);

    // Pointer wrap between 3 and 0.
    applyStimulus(4'b1000, 1);
    applyStimulus(4'b0000, 9);
    applyStimulus(4'b1001, 1);
    applyStimulus(4'b0000, 9);
    applyStimulus(4'b1001, 1);
    applyStimulus(4'b0000, 9);

    // Data changes during HOLD must not reach the bus.
    setData(1, 8'h33);
    applyStimulus(4'b0010, 1);
    applyStimulus(4'b0000, 1);
    setData(1, 8'hCC);
    applyStimulus(4'b0000, 12);

    // Reset two cycles into HOLD, then restart from requester 0's priority.
    applyStimulus(4'b0001, 1);
    applyStimulus(4'b0000, 2);
    applyReset();
    applyStimulus(4'b1010, 1);
    applyStimulus(4'b0000, 10);

    // Requests only while busy are ignored.
    applyStimulus(4'b0100, 1);
    for (int k = 0; k < H + G; k++) applyStimulus(4'($urandom_range(1, 15)), 1);
    applyStimulus(4'b0000, 12);

    // Random traffic.
    repeat (1500) begin
      for (int i = 0; i < N; i++) setData(i, W'($urandom));
      if ($urandom_range(0, 1) == 0) applyStimulus(4'b0000, 1);
      else applyStimulus(4'($urandom_range(0, 15)), 1);
    end
    applyStimulus(4'b0000, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
